// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue -- two-cycle instruction issue stage in front of an external ALU.
//
// Holds an 8 x 16 register file (r0 hardwired to zero). An instruction accepted
// in IDLE loads the registered ALU operands/op. In EXEC, the external
// combinational ALU result is written back to the register file and reported
// on the wb_* strobe.
//
// Parameter
//   IMM_SEXT     0: imm6 is zero-extended, 1: imm6 is sign-extended to 16 bits
// Optional feature
//   ALU_ISSUE_RETIRE_CNT_EN  when defined, adds output retire_cnt[15:0], a
//                            wrapping count of wb_valid pulses
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   instr_valid/ready   instruction handshake (ready only in IDLE)
//   instr[15:0]         [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt,
//                       [5:0] imm6, [0] shift direction
//   alu_a/alu_b/alu_op  registered ALU operands and op_type
//   alu_one_zero        registered shift direction (1 = right)
//   alu_result/zero     combinational ALU result and Zero flag
//   wb_valid/rd/data/zero  one-cycle writeback strobe with payload
//   illegal_op          one-cycle pulse when an op > 8 retires
// -----------------------------------------------------------------------------
module alu_issue #(
  parameter int IMM_SEXT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_one_zero,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        wb_zero,
  output logic        illegal_op
`ifdef ALU_ISSUE_RETIRE_CNT_EN
  ,
  output logic [15:0] retire_cnt
`endif
);

  localparam logic [3:0] OP_SHIFT = 4'd5;
  localparam logic [3:0] OP_NOP   = 4'd6;
  localparam logic [3:0] OP_IMMA  = 4'd7;
  localparam logic [3:0] OP_IMMB  = 4'd8;

  typedef enum logic {IDLE, EXEC} state_t;

  function automatic logic [15:0] ext_imm(input logic [5:0] imm);
    if (IMM_SEXT != 0) return {{10{imm[5]}}, imm};
    else               return {10'd0, imm};
  endfunction

  state_t      state_q, state_d;
  logic [15:0] rf_q [8];
  logic [15:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        one_zero_q, one_zero_d;
  logic [2:0]  rd_q, rd_d;
  logic        wr_pend_q, wr_pend_d;   // EXEC will retire a writeback
  logic        ill_pend_q, ill_pend_d; // EXEC will retire an illegal op
  logic        wb_valid_q, wb_valid_d;
  logic [2:0]  wb_rd_q, wb_rd_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        wb_zero_q, wb_zero_d;
  logic        illegal_q, illegal_d;
  logic        rf_we;

  logic [3:0]  op;
  logic [2:0]  rd, rs, rt;
  logic [5:0]  imm6;

  assign op   = instr[15:12];
  assign rd   = instr[11:9];
  assign rs   = instr[8:6];
  assign rt   = instr[5:3];
  assign imm6 = instr[5:0];

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    one_zero_d = one_zero_q;
    rd_d       = rd_q;
    wr_pend_d  = wr_pend_q;
    ill_pend_d = ill_pend_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_zero_d  = wb_zero_q;
    illegal_d  = 1'b0;
    rf_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          alu_a_d    = rf_q[rs];
          alu_b_d    = (op == OP_IMMA || op == OP_IMMB) ? ext_imm(imm6) : rf_q[rt];
          // Illegal ops present as NOP to the ALU.
          alu_op_d   = (op > OP_IMMB) ? OP_NOP : op;
          one_zero_d = (op == OP_SHIFT) ? instr[0] : 1'b0;
          rd_d       = rd;
          wr_pend_d  = (op <= OP_IMMB) && (op != OP_NOP);
          ill_pend_d = (op > OP_IMMB);
          state_d    = EXEC;
        end
      end
      EXEC: begin
        state_d   = IDLE;
        illegal_d = ill_pend_q;
        if (wr_pend_q) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = alu_result;
          wb_zero_d  = alu_zero;
          // r0 still reports a writeback but the value is dropped.
          rf_we      = (rd_q != 3'd0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= OP_NOP;
      one_zero_q <= 1'b0;
      rd_q       <= '0;
      wr_pend_q  <= 1'b0;
      ill_pend_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_zero_q  <= 1'b0;
      illegal_q  <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      one_zero_q <= one_zero_d;
      rd_q       <= rd_d;
      wr_pend_q  <= wr_pend_d;
      ill_pend_q <= ill_pend_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_zero_q  <= wb_zero_d;
      illegal_q  <= illegal_d;
      if (rf_we) rf_q[rd_q] <= alu_result;
    end
  end

`ifdef ALU_ISSUE_RETIRE_CNT_EN
  logic [15:0] retire_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           retire_cnt_q <= '0;
    else if (wb_valid_d) retire_cnt_q <= retire_cnt_q + 16'd1;
  end
  assign retire_cnt = retire_cnt_q;
`endif

  // Ready is masked by reset so it is low for the whole reset window.
  assign instr_ready  = (state_q == IDLE) && !reset;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign alu_one_zero = one_zero_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_zero      = wb_zero_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue -- directed self-checking bench for alu_issue.
// Two instances share stimulus: u0 (IMM_SEXT=0) and u1 (IMM_SEXT=1). Each has
// its own behavioural ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shift by
// b[3:0] (dir 1 = right), 7 add, 8 sub, others 0.
// -----------------------------------------------------------------------------
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;

  logic        rdy0, rdy1, oz0, oz1, z0, z1, wbv0, wbv1, wbz0, wbz1, ill0, ill1;
  logic [15:0] a0, a1, b0, b1, res0, res1, wbd0, wbd1;
  logic [3:0]  op0, op1;
  logic [2:0]  wbr0, wbr1;
`ifdef ALU_ISSUE_RETIRE_CNT_EN
  logic [15:0] rc0, rc1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op, input logic dir);
    case (op)
      4'd0, 4'd7: return a + b;
      4'd1, 4'd8: return a - b;
      4'd2:       return a & b;
      4'd3:       return a | b;
      4'd4:       return a ^ b;
      4'd5:       return dir ? (a >> b[3:0]) : (a << b[3:0]);
      default:    return 16'h0000;
    endcase
  endfunction

  assign res0 = alu_model(a0, b0, op0, oz0);
  assign res1 = alu_model(a1, b1, op1, oz1);
  assign z0   = (res0 == 16'h0000);
  assign z1   = (res1 == 16'h0000);

  alu_issue #(.IMM_SEXT(0)) u0 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(rdy0),
    .instr(instr), .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_one_zero(oz0),
    .alu_result(res0), .alu_zero(z0), .wb_valid(wbv0), .wb_rd(wbr0),
    .wb_data(wbd0), .wb_zero(wbz0), .illegal_op(ill0)
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    , .retire_cnt(rc0)
`endif
  );

  alu_issue #(.IMM_SEXT(1)) u1 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(rdy1),
    .instr(instr), .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_one_zero(oz1),
    .alu_result(res1), .alu_zero(z1), .wb_valid(wbv1), .wb_rd(wbr1),
    .wb_data(wbd1), .wb_zero(wbz1), .illegal_op(ill1)
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    , .retire_cnt(rc1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [31:0] o0, input logic [31:0] o1,
                      input logic [31:0] exp);
    chk({"u0 ", tag}, o0, exp);
    chk({"u1 ", tag}, o1, exp);
  endtask

  // Offer one instruction at the negedge; returns #1 after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [5:0] lo);
    @(negedge clk);
    chk2("ready_before_issue", rdy0, rdy1, 1);
    instr       = {op, rd, rs, lo};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic [2:0] rd, input logic [15:0] data,
                        input logic zero);
    chk2({tag, " wb_valid"}, wbv0, wbv1, 1);
    chk2({tag, " wb_rd"},    wbr0, wbr1, rd);
    chk2({tag, " wb_data"},  wbd0, wbd1, data);
    chk2({tag, " wb_zero"},  wbz0, wbz1, zero);
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    #12;
    chk2("rst instr_ready", rdy0, rdy1, 0);
    chk2("rst alu_op",      op0, op1, 6);
    chk2("rst alu_a",       a0, a1, 0);
    chk2("rst wb_valid",    wbv0, wbv1, 0);
    chk2("rst illegal_op",  ill0, ill1, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk2("post-rst ready", rdy0, rdy1, 1);

    // r1 = r0 + 5
    issue(4'd7, 3'd1, 3'd0, 6'd5);
    chk2("op7 alu_a", a0, a1, 16'h0000);
    chk2("op7 alu_b", b0, b1, 16'h0005);
    chk2("op7 alu_op", op0, op1, 7);
    chk2("exec ready", rdy0, rdy1, 0);
    step();
    chk_wb("r1=5", 3'd1, 16'h0005, 1'b0);

    // r2 = r0 + 3, then r3 = r1 - r1 (issued while previous wb_valid is high)
    issue(4'd7, 3'd2, 3'd0, 6'd3);
    chk2("wb pulse ends", wbv0, wbv1, 0);
    step();
    chk_wb("r2=3", 3'd2, 16'h0003, 1'b0);
    issue(4'd1, 3'd3, 3'd1, {3'd1, 3'd0});
    chk2("sub reads updated r1 b", b0, b1, 16'h0005);
    step();
    chk_wb("r3=r1-r1", 3'd3, 16'h0000, 1'b1);
    issue(4'd0, 3'd5, 3'd3, {3'd2, 3'd0});
    chk2("RF[3] read", a0, a1, 16'h0000);
    chk2("RF[2] read", b0, b1, 16'h0003);
    step();

    // Build r1 = 0x8000 via r1 = 1 and r4 = 15, then shift left
    issue(4'd7, 3'd1, 3'd0, 6'd1);
    step();
    issue(4'd7, 3'd4, 3'd0, 6'd15);
    step();
    issue(4'd5, 3'd1, 3'd1, {3'd4, 3'd0});
    step();
    chk_wb("r1=0x8000", 3'd1, 16'h8000, 1'b0);
    issue(4'd5, 3'd6, 3'd1, {3'd2, 3'd1});
    chk2("shr one_zero", oz0, oz1, 1);
    step();
    chk_wb("shr 3", 3'd6, 16'h1000, 1'b0);
    issue(4'd5, 3'd6, 3'd1, {3'd2, 3'd0});
    chk2("shl one_zero", oz0, oz1, 0);
    step();
    chk_wb("shl 3", 3'd6, 16'h0000, 1'b1);
    // one_zero forced to 0 for non-shift op even with instr[0]=1
    issue(4'd2, 3'd7, 3'd1, {3'd1, 3'd1});
    chk2("and one_zero", oz0, oz1, 0);
    step();
    chk_wb("and", 3'd7, 16'h8000, 1'b0);

    // Write to r0 reported but discarded
    issue(4'd7, 3'd0, 3'd0, 6'd9);
    step();
    chk_wb("r0 write", 3'd0, 16'h0009, 1'b0);
    issue(4'd0, 3'd5, 3'd0, {3'd0, 3'd0});
    chk2("RF[0] still 0", a0, a1, 16'h0000);
    step();

    // Illegal op 12
    issue(4'd12, 3'd2, 3'd1, 6'd0);
    chk2("illegal alu_op", op0, op1, 6);
    chk2("illegal early", ill0, ill1, 0);
    step();
    chk2("illegal pulse", ill0, ill1, 1);
    chk2("illegal wb_valid", wbv0, wbv1, 0);
    step();
    chk2("illegal pulse ends", ill0, ill1, 0);

    // NOP: EXEC cycle spent, no writeback
    issue(4'd6, 3'd2, 3'd1, 6'd0);
    chk2("nop exec ready", rdy0, rdy1, 0);
    step();
    chk2("nop wb_valid", wbv0, wbv1, 0);
    chk2("nop illegal", ill0, ill1, 0);
    chk2("nop wb_data held", wbd0, wbd1, 16'h0000);
    // r2 unchanged by illegal/NOP
    issue(4'd0, 3'd5, 3'd2, {3'd0, 3'd0});
    chk2("r2 untouched", a0, a1, 16'h0003);
    step();

    // Idle hold
    repeat (3) step();
    chk2("idle ready", rdy0, rdy1, 1);
    chk2("idle alu_a hold", a0, a1, 16'h0003);
    chk2("idle wb_data hold", wbd0, wbd1, 16'h0003);

    // Reset during EXEC aborts op 7 rd=4 imm6=7
    issue(4'd7, 3'd4, 3'd0, 6'd7);
    #2 reset = 1'b1;
    #1;
    chk2("async rst ready", rdy0, rdy1, 0);
    chk2("async rst alu_op", op0, op1, 6);
    chk2("async rst alu_b", b0, b1, 16'h0000);
    step();
    chk2("abort wb_valid", wbv0, wbv1, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk2("abort ready", rdy0, rdy1, 1);
    issue(4'd0, 3'd5, 3'd4, {3'd0, 3'd0});
    chk2("RF[4] after abort", a0, a1, 16'h0000);
    step();

    // Immediate extension: r1 = 1, then r1 = r1 + imm6 0x3F
    issue(4'd7, 3'd1, 3'd0, 6'd1);
    step();
    issue(4'd7, 3'd1, 3'd1, 6'h3F);
    chk("u0 zext alu_b", b0, 16'h003F);
    chk("u1 sext alu_b", b1, 16'hFFFF);
    step();
    chk("u1 sext wb_data", wbd1, 16'h0000);
    chk("u1 sext wb_zero", wbz1, 1);
    chk("u0 zext wb_data", wbd0, 16'h0040);
    chk("u0 zext wb_zero", wbz0, 0);

`ifdef ALU_ISSUE_RETIRE_CNT_EN
    @(negedge clk);
    reset = 1'b1;
    #1 chk2("retire_cnt reset", rc0, rc1, 0);
    @(negedge clk);
    reset       = 1'b0;
    instr       = {4'd7, 3'd7, 3'd0, 6'd1};
    instr_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk2("retire_cnt one", rc0, rc1, 1);
    repeat (2 * 65536 - 2) @(posedge clk);
    #1 instr_valid = 1'b0;
    chk2("retire_cnt wrap", rc0, rc1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
